round_sequencer: RTL and testbench

- Drives the Stop/restart side of the reaction game; it is the producer of the signals that the counter pair and win/lose judge consume.
- Conditions the raw player button (synchronise and debounce), asserts Stop to freeze the counters, samples the judge's Win/Lose verdict, and keeps running scores.
- After a hold period and button release, it pulses a game reset so the counters restart for the next round.

---
 rtl/round_sequencer_if.sv | 25 ++
 rtl/round_sequencer.sv | 129 ++++++++++++
 tb/tb_round_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// Player/judge/counter-side signal bundle for the round sequencer.
// master = the sequencer itself, slave = the game environment (button, judge, counters).
interface round_sequencer_if #(
  parameter int SCORE_W = 4
);
  logic               button;
  logic               win;
  logic               lose;
  logic               stop;
  logic               game_reset;
  logic               busy;
  logic [SCORE_W-1:0] wins;
  logic [SCORE_W-1:0] losses;
  logic [SCORE_W-1:0] streak;

  modport master (
    input  button, win, lose,
    output stop, game_reset, busy, wins, losses, streak
  );

  modport slave (
    output button, win, lose,
    input  stop, game_reset, busy, wins, losses, streak
  );
endinterface

// File: rtl/round_sequencer.sv
// Reaction-game round sequencer: button conditioning, Stop/verdict sampling, scores, GameReset.
// Optional win-streak counter built only when ROUND_STREAK_EN is defined.
module round_sequencer #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  round_sequencer_if.master sif
);
  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_STOPPED = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES);

  logic [1:0]         sync_q, sync_d;
  logic               deb_q, deb_d;
  logic [7:0]         deb_cnt_q, deb_cnt_d;
  logic               press_q, press_d;
  logic [2:0]         state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               stop_q, stop_d;
  logic               game_reset_q, game_reset_d;
  logic [SCORE_W-1:0] wins_q, wins_d;
  logic [SCORE_W-1:0] losses_q, losses_d;
  logic               win_evt, lose_evt;

  // The debounced level flips on the DEB_CYCLES-th consecutive differing cycle.
  always_comb begin
    sync_d    = {sync_q[0], sif.button};
    deb_d     = deb_q;
    deb_cnt_d = '0;
    press_d   = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d   = ~deb_q;
        press_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wins_d   = wins_q;
    losses_d = losses_q;
    win_evt  = 1'b0;
    lose_evt = 1'b0;
    case (state_q)
      S_INIT:    state_d = S_RUN;
      S_RUN:     if (press_q) state_d = S_STOPPED;
      S_STOPPED: begin
        win_evt  = sif.win & ~sif.lose;
        lose_evt = sif.lose & ~sif.win;
        hold_d   = HOLD_LD;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        // A still-pressed button keeps the round frozen past the hold period.
        if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
        else if (!deb_q)    state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_RUN;
      default:   state_d = S_INIT;
    endcase
    if (win_evt && wins_q != '1)    wins_d   = wins_q + 1'b1;
    if (lose_evt && losses_q != '1) losses_d = losses_q + 1'b1;
    stop_d       = (state_d == S_STOPPED) || (state_d == S_HOLD);
    game_reset_d = (state_d == S_INIT) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      deb_q        <= 1'b0;
      deb_cnt_q    <= '0;
      press_q      <= 1'b0;
      state_q      <= S_INIT;
      hold_q       <= '0;
      stop_q       <= 1'b0;
      game_reset_q <= 1'b1;
      wins_q       <= '0;
      losses_q     <= '0;
    end else begin
      sync_q       <= sync_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= press_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      stop_q       <= stop_d;
      game_reset_q <= game_reset_d;
      wins_q       <= wins_d;
      losses_q     <= losses_d;
    end
  end

`ifdef ROUND_STREAK_EN
  logic [SCORE_W-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (win_evt && streak_q != '1) streak_d = streak_q + 1'b1;
    else if (lose_evt)             streak_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end

  assign sif.streak = streak_q;
`else
  assign sif.streak = '0;
`endif

  assign sif.stop       = stop_q;
  assign sif.game_reset = game_reset_q;
  assign sif.busy       = (state_q != S_RUN);
  assign sif.wins       = wins_q;
  assign sif.losses     = losses_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Randomized scoreboard bench for round_sequencer: stimulus pushes expected round outcomes,
// a negedge monitor pops one per GameReset pulse that ends a round.
module tb_round_sequencer;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int SW   = 4;
  localparam int MAXV = (1 << SW) - 1;

  typedef struct {
    int wins;
    int losses;
    int streak;
    int slen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   m_wins = 0, m_losses = 0, m_streak = 0;
  int   slen = 0, glen = 0;

  round_sequencer_if #(.SCORE_W(SW)) sif ();

  round_sequencer #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .SCORE_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Score rules applied to one sampled verdict; h = extra edges button stays pressed after Stop.
  task automatic model_round(input bit w, input bit l, input int h);
    exp_t e;
    if (w && !l) begin
      if (m_wins < MAXV) m_wins++;
`ifdef ROUND_STREAK_EN
      if (m_streak < MAXV) m_streak++;
`endif
    end else if (l && !w) begin
      if (m_losses < MAXV) m_losses++;
      m_streak = 0;
    end
    e.wins   = m_wins;
    e.losses = m_losses;
    e.streak = m_streak;
    e.slen   = imax(HOLD + 2, h + DEB + 3);
    exp_q.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pop when a round's GameReset appears.
  always @(negedge clk) begin
    if (!rst_n) begin
      slen = 0;
      glen = 0;
    end else begin
      chk("busy_vs_state", int'(sif.busy), int'(sif.stop | sif.game_reset));
      if (sif.stop) slen++;
      if (sif.game_reset) begin
        glen++;
        if (slen != 0) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_round", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_wins", int'(sif.wins), e.wins);
            chk("sb_losses", int'(sif.losses), e.losses);
            chk("sb_streak", int'(sif.streak), e.streak);
            chk("sb_stop_len", slen, e.slen);
          end
          slen = 0;
        end
      end else if (glen != 0) begin
        chk("game_reset_width", glen, 1);
        glen = 0;
      end
    end
  end

  task automatic wait_stop(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!sif.stop && k < 40);
  endtask

  task automatic run_round(input bit w, input bit l, input int h, input bit detail);
    int k;
    sif.button = 1'b1;
    sif.win    = w;
    sif.lose   = l;
    wait_stop(k);
    chk("stop_latency", k, DEB + 3);
    model_round(w, l, h);
    repeat (h) tick();
    sif.button = 1'b0;
    if (detail) begin
      tick();
      chk("wins_after_sample", int'(sif.wins), m_wins);
      chk("stop_in_hold", int'(sif.stop), 1);
    end
    k = 0;
    while (sif.busy && k < 300) begin
      tick();
      k++;
    end
    chk("round_done", int'(sif.busy), 0);
    chk("stop_low_in_run", int'(sif.stop), 0);
    sif.win  = 1'b0;
    sif.lose = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
  endtask

  task automatic glitch(input int g);
    int seen;
    seen = 0;
    sif.button = 1'b1;
    repeat (g) tick();
    sif.button = 1'b0;
    repeat (DEB + 6) begin
      tick();
      if (sif.stop || sif.busy) seen = 1;
    end
    chk("glitch_no_stop", seen, 0);
  endtask

  initial begin
    int k;
    int v;
    sif.button = 1'b0;
    sif.win    = 1'b0;
    sif.lose   = 1'b0;
    repeat (3) tick();
    chk("rst_stop", int'(sif.stop), 0);
    chk("rst_game_reset", int'(sif.game_reset), 1);
    chk("rst_wins", int'(sif.wins), 0);
    chk("rst_losses", int'(sif.losses), 0);
    chk("rst_streak", int'(sif.streak), 0);
    chk("rst_busy", int'(sif.busy), 1);
    rst_n = 1'b1;
    tick();
    chk("run_game_reset", int'(sif.game_reset), 0);
    chk("run_stop", int'(sif.stop), 0);
    chk("run_busy", int'(sif.busy), 0);
    repeat (2) tick();

    glitch(1);
    glitch(3);
    repeat (3) glitch($urandom_range(1, DEB - 1));

    run_round(1'b1, 1'b0, 0, 1'b1);
    run_round(1'b1, 1'b0, 50, 1'b0);
    run_round(1'b1, 1'b0, 2, 1'b0);
    run_round(1'b0, 1'b1, 0, 1'b0);
    run_round(1'b1, 1'b1, 1, 1'b0);
    run_round(1'b0, 1'b0, 0, 1'b0);
    repeat (16) run_round(1'b0, 1'b1, $urandom_range(0, 3), 1'b0);
    chk("losses_saturated", int'(sif.losses), MAXV);
    repeat (20) begin
      v = $urandom_range(0, 3);
      run_round(v[0], v[1], $urandom_range(0, 15), 1'b0);
      if ($urandom_range(0, 2) == 0) glitch($urandom_range(1, DEB - 1));
    end

    // Abort a round while in HOLD with an asynchronous reset.
    sif.button = 1'b1;
    sif.win    = 1'b1;
    wait_stop(k);
    chk("abort_latency", k, DEB + 3);
    repeat (3) tick();
    chk("abort_in_hold", int'(sif.stop), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_stop", int'(sif.stop), 0);
    chk("abort_game_reset", int'(sif.game_reset), 1);
    chk("abort_wins", int'(sif.wins), 0);
    chk("abort_losses", int'(sif.losses), 0);
    chk("abort_streak", int'(sif.streak), 0);
    m_wins = 0;
    m_losses = 0;
    m_streak = 0;
    sif.button = 1'b0;
    sif.win    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("abort_rerun_busy", int'(sif.busy), 0);
    run_round(1'b1, 1'b0, 0, 1'b1);

    repeat (4) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
